// File: rtl/srl_dly_ctrl_pkg.sv
// Shared constants and types for the SRL-based programmable delay controller.
package srl_dly_ctrl_pkg;

  localparam int unsigned DLY_W     = 4;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned SRL_DEPTH = 16;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_FILL = 1'b1
  } state_e;

endpackage

// File: rtl/srl_16dx1.sv
// 16-deep, 1-bit addressable shift register with clock enable (SRL16E-style).
module srl_16dx1
  import srl_dly_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             CE,
  input  logic [DLY_W-1:0] A,
  input  logic             I,
  output logic             O
);

  logic [SRL_DEPTH-1:0] sr_q;
  logic [SRL_DEPTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (CE) begin
      sr_d = {sr_q[SRL_DEPTH-2:0], I};
    end
  end

  // Contents are deliberately unreset; the controller's fill sequence guarantees validity.
  always_ff @(posedge CLK) begin
    sr_q <= sr_d;
  end

  assign O = sr_q[A];

endmodule

// File: rtl/srl_dly_ctrl.sv
// Programmable 1-bit delay line controller: loads a new tap address and
// suppresses the output until the line has refilled at the new depth.
module srl_dly_ctrl
  import srl_dly_ctrl_pkg::*;
#(
  parameter logic [DLY_W-1:0] DEF_DLY = 4'd4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIN,
  input  logic             WR,
  input  logic [DLY_W-1:0] DLY_IN,
  output logic             DOUT,
  output logic             BUSY,
  output logic [DLY_W-1:0] DLY_CUR,
  output logic             WR_ERR
);

  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(DEF_DLY) + CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] dly_cur_q, dly_cur_d;
  logic             busy_q, busy_d;
  logic             wr_err_q, wr_err_d;
  logic             tap;

  srl_16dx1 u_line (
    .CLK (CLK),
    .CE  (EN),
    .A   (dly_cur_q),
    .I   (DIN),
    .O   (tap)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dly_cur_d = dly_cur_q;
    busy_d    = busy_q;
    wr_err_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        // Accepted regardless of EN; the WR cycle itself is not counted.
        if (WR) begin
          dly_cur_d = DLY_IN;
          cnt_d     = CNT_W'(DLY_IN) + CNT_W'(1);
          busy_d    = 1'b1;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        if (WR) begin
          wr_err_d = 1'b1;
        end
        if (EN) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            busy_d  = 1'b0;
            state_d = ST_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_FILL;
      cnt_q     <= CNT_RST;
      dly_cur_q <= DEF_DLY;
      busy_q    <= 1'b1;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dly_cur_q <= dly_cur_d;
      busy_q    <= busy_d;
      wr_err_q  <= wr_err_d;
    end
  end

  // Tap is gated so stale line contents never reach the output during a refill.
  assign DOUT    = (state_q == ST_RUN) && tap;
  assign BUSY    = busy_q;
  assign DLY_CUR = dly_cur_q;
  assign WR_ERR  = wr_err_q;

endmodule

// File: tb/tb_srl_dly_ctrl.sv
// Directed self-checking bench for srl_dly_ctrl with hand-computed expectations.
module tb_srl_dly_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic       DIN;
  logic       WR;
  logic [3:0] DLY_IN;
  logic       DOUT;
  logic       BUSY;
  logic [3:0] DLY_CUR;
  logic       WR_ERR;

  int n_chk  = 0;
  int n_pass = 0;

  srl_dly_ctrl #(.DEF_DLY(4'd4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .DIN     (DIN),
    .WR      (WR),
    .DLY_IN  (DLY_IN),
    .DOUT    (DOUT),
    .BUSY    (BUSY),
    .DLY_CUR (DLY_CUR),
    .WR_ERR  (WR_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive one cycle of inputs, clock it, and settle just after the edge.
  task automatic cyc(input logic en, input logic din, input logic wr, input logic [3:0] dly);
    EN = en; DIN = din; WR = wr; DLY_IN = dly;
    @(posedge CLK);
    #1;
  endtask

  // Enabled cycles with DIN=0 until BUSY drops; DOUT must stay 0 throughout.
  task automatic fill_len(input string tag, output int n);
    int bad;
    n = 0; bad = 0;
    while (BUSY && n < 40) begin
      if (DOUT) bad++;
      cyc(1'b1, 1'b0, 1'b0, 4'd0);
      n++;
    end
    check({tag, "_dout_gated"}, bad, 0);
  endtask

  // One-cycle DIN pulse, then count enabled clocks until it reaches DOUT.
  task automatic latency(output int lat);
    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    lat = 1;
    while (!DOUT && lat < 40) begin
      cyc(1'b1, 1'b0, 1'b0, 4'd0);
      lat++;
    end
  endtask

  initial begin
    int n;
    int lat;
    RST = 1'b1; EN = 1'b0; DIN = 1'b0; WR = 1'b0; DLY_IN = 4'd0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", BUSY, 1);
    check("rst_dly", DLY_CUR, 4);
    check("rst_dout", DOUT, 0);
    check("rst_wrerr", WR_ERR, 0);
    RST = 1'b0;

    // Default fill after reset release
    fill_len("def_fill", n);
    check("def_fill_len", n, 5);
    latency(lat);
    check("def_lat", lat, 5);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    check("def_pulse_end", DOUT, 0);

    // Load 9 in RUN
    cyc(1'b1, 1'b0, 1'b1, 4'd9);
    check("wr9_dly", DLY_CUR, 9);
    check("wr9_busy", BUSY, 1);
    check("wr9_noerr", WR_ERR, 0);
    check("wr9_dout", DOUT, 0);
    fill_len("wr9_fill", n);
    check("wr9_fill_len", n, 10);
    latency(lat);
    check("wr9_lat", lat, 10);

    // Rejected WR during FILL
    cyc(1'b1, 1'b0, 1'b1, 4'd5);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b1, 4'd2);
    check("rej_err", WR_ERR, 1);
    check("rej_dly", DLY_CUR, 5);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    check("rej_err_pulse", WR_ERR, 0);
    fill_len("rej_fill", n);
    check("rej_fill_len", n, 3);
    check("rej_dly_after", DLY_CUR, 5);

    // Toggling EN during FILL; DIN=1 on frozen cycles must not enter the line
    cyc(1'b1, 1'b0, 1'b1, 4'd3);
    n = 0;
    while (BUSY && n < 40) begin
      cyc(1'(n % 2), 1'(1 - (n % 2)), 1'b0, 4'd0);
      n++;
    end
    check("tog_fill_clocks", n, 8);
    check("tog_hold_dout", DOUT, 0);
    latency(lat);
    check("tog_lat", lat, 4);

    // WR accepted in RUN with EN=0, then extremes 15 and 0
    cyc(1'b0, 1'b0, 1'b1, 4'd15);
    check("en0_wr_dly", DLY_CUR, 15);
    check("en0_wr_busy", BUSY, 1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'd0);
    check("en0_frozen_busy", BUSY, 1);
    fill_len("d15_fill", n);
    check("d15_fill_len", n, 16);
    latency(lat);
    check("d15_lat", lat, 16);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b1, 4'd0);
    check("d0_dly", DLY_CUR, 0);
    fill_len("d0_fill", n);
    check("d0_fill_len", n, 1);
    latency(lat);
    check("d0_lat", lat, 1);

    // Reset in the middle of a FILL for 12
    cyc(1'b1, 1'b0, 1'b1, 4'd12);
    check("wr12_dly", DLY_CUR, 12);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 4'd0);
    RST = 1'b1;
    #1;
    check("mid_rst_dly", DLY_CUR, 4);
    check("mid_rst_busy", BUSY, 1);
    check("mid_rst_dout", DOUT, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    fill_len("mid_rst_fill", n);
    check("mid_rst_fill_len", n, 5);
    latency(lat);
    check("mid_rst_lat", lat, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
